// File: rtl/cam_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cam_ctrl_pkg                                               |
// | Description : Shared definitions for the CAM access arbiter: controller  |
// |               state encoding and the geometry of the shared CAM.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package cam_ctrl_pkg;

   // Controller states. Every access is a LOOKUP+UPDATE pair so the CAM
   // always ends up back in its read phase.
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOOKUP  = 3'd1,
      S_UPDATE  = 3'd2,
      S_CAPTURE = 3'd3,
      S_RESP    = 3'd4
   } state_t;

   // Geometry of the shared CAM instance (16 entries of 8 bits).
   localparam int CAM_DEPTH      = 16;
   localparam int CAM_WIDTH      = 8;
   localparam int CAM_ADDR_WIDTH = 4;

endpackage
`default_nettype wire

// File: rtl/cam_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cam_rr_arbiter                                             |
// | Description : Combinational round-robin grant. The search starts at ptr  |
// |               and the first asserted request at or after ptr wins,       |
// |               wrapping around. The pointer register lives in the parent. |
// | Ports       : req        - request vector                                |
// |               ptr        - search start index (0..NUM_REQ-1)             |
// |               grant      - one-hot grant                                 |
// |               grant_idx  - encoded index of the granted requester        |
// |               any_grant  - at least one request is asserted              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module cam_rr_arbiter
   import cam_ctrl_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int ID_WIDTH = 2
) (
   input  logic [NUM_REQ-1:0]  req,
   input  logic [ID_WIDTH-1:0] ptr,
   output logic [NUM_REQ-1:0]  grant,
   output logic [ID_WIDTH-1:0] grant_idx,
   output logic                any_grant
);

   int w_idx;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any_grant = 1'b0;
      w_idx     = 0;
      // Walk the requesters in priority order ptr, ptr+1, ... (mod NUM_REQ).
      for (int k = 0; k < NUM_REQ; k++) begin
         w_idx = int'(ptr) + k;
         if (w_idx >= NUM_REQ) begin
            w_idx = w_idx - NUM_REQ;
         end
         if (!any_grant && req[w_idx]) begin
            any_grant     = 1'b1;
            grant[w_idx]  = 1'b1;
            grant_idx     = ID_WIDTH'(w_idx);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/cam_access_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cam_access_arbiter                                         |
// | Description : Shares one CAM between NUM_REQ requesters. Grants round-   |
// |               robin, sequences the CAM lookup then update phases,        |
// |               returns a tagged hit/miss response and keeps saturating    |
// |               hit/miss statistics.                                       |
// | Ports       : clk, reset          - clock, sync active-high reset        |
// |               req_valid/req_key   - per-requester request and key        |
// |               req_ready           - one-hot grant/accept pulse (IDLE)    |
// |               rsp_valid/rsp_ready - response handshake                   |
// |               rsp_id/hit/addr     - response tag, hit flag, match addr   |
// |               cam_en/we/din       - CAM control (registered)             |
// |               cam_match/addr      - CAM result                           |
// |               busy                - transaction in flight                |
// |               hit_count/miss_count- saturating statistics                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module cam_access_arbiter
   import cam_ctrl_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int WIDTH      = CAM_WIDTH,
   parameter int ADDR_WIDTH = CAM_ADDR_WIDTH,
   parameter int ID_WIDTH   = 2,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*WIDTH-1:0]   req_key,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       rsp_valid,
   output logic [ID_WIDTH-1:0]        rsp_id,
   output logic                       rsp_hit,
   output logic [ADDR_WIDTH-1:0]      rsp_addr,
   input  logic                       rsp_ready,
   output logic                       cam_en,
   output logic                       cam_we,
   output logic [WIDTH-1:0]           cam_din,
   input  logic                       cam_match,
   input  logic [ADDR_WIDTH-1:0]      cam_match_addr,
   output logic                       busy,
   output logic [CNT_WIDTH-1:0]       hit_count,
   output logic [CNT_WIDTH-1:0]       miss_count
);

   state_t                  r_state;
   logic [ID_WIDTH-1:0]     r_ptr;
   logic [WIDTH-1:0]        r_key;
   logic [ID_WIDTH-1:0]     r_id;
   logic                    r_cam_en;
   logic                    r_cam_we;
   logic                    r_rsp_valid;
   logic [ID_WIDTH-1:0]     r_rsp_id;
   logic                    r_rsp_hit;
   logic [ADDR_WIDTH-1:0]   r_rsp_addr;
   logic [CNT_WIDTH-1:0]    r_hit_count;
   logic [CNT_WIDTH-1:0]    r_miss_count;

   logic [NUM_REQ-1:0]      w_grant;
   logic [ID_WIDTH-1:0]     w_grant_idx;
   logic                    w_any_grant;
   logic [WIDTH-1:0]        w_sel_key;
   logic [ID_WIDTH-1:0]     w_ptr_next;

   cam_rr_arbiter #(
      .NUM_REQ  (NUM_REQ),
      .ID_WIDTH (ID_WIDTH)
   ) u_rr_arbiter (
      .req       (req_valid),
      .ptr       (r_ptr),
      .grant     (w_grant),
      .grant_idx (w_grant_idx),
      .any_grant (w_any_grant)
   );

   // Key of the winning requester, selected by the one-hot grant.
   always_comb begin
      w_sel_key = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_grant[i]) begin
            w_sel_key = req_key[i*WIDTH +: WIDTH];
         end
      end
   end

   assign w_ptr_next = (w_grant_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0
                                                               : w_grant_idx + 1'b1;

   // The accept pulse must coincide with the cycle the key is latched, so it
   // is decoded from the state register rather than registered itself. It is
   // masked during reset so that every output reads 0 while reset is held.
   assign req_ready  = (r_state == S_IDLE && !reset) ? w_grant : '0;

   assign busy       = (r_state != S_IDLE);
   assign cam_en     = r_cam_en;
   assign cam_we     = r_cam_we;
   assign cam_din    = r_key;
   assign rsp_valid  = r_rsp_valid;
   assign rsp_id     = r_rsp_id;
   assign rsp_hit    = r_rsp_hit;
   assign rsp_addr   = r_rsp_addr;
   assign hit_count  = r_hit_count;
   assign miss_count = r_miss_count;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_ptr        <= '0;
         r_key        <= '0;
         r_id         <= '0;
         r_cam_en     <= 1'b0;
         r_cam_we     <= 1'b0;
         r_rsp_valid  <= 1'b0;
         r_rsp_id     <= '0;
         r_rsp_hit    <= 1'b0;
         r_rsp_addr   <= '0;
         r_hit_count  <= '0;
         r_miss_count <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any_grant) begin
                  r_key    <= w_sel_key;
                  r_id     <= w_grant_idx;
                  r_ptr    <= w_ptr_next;
                  // CAM controls are registered, so they are set up here to
                  // be valid for the whole LOOKUP cycle.
                  r_cam_en <= 1'b1;
                  r_cam_we <= 1'b0;
                  r_state  <= S_LOOKUP;
               end
            end
            S_LOOKUP: begin
               r_cam_en <= 1'b1;
               r_cam_we <= 1'b1;
               r_state  <= S_UPDATE;
            end
            S_UPDATE: begin
               r_cam_en <= 1'b0;
               r_cam_we <= 1'b0;
               r_state  <= S_CAPTURE;
            end
            S_CAPTURE: begin
               r_rsp_hit   <= cam_match;
               r_rsp_addr  <= cam_match ? cam_match_addr : '0;
               r_rsp_id    <= r_id;
               r_rsp_valid <= 1'b1;
               if (cam_match) begin
                  if (r_hit_count != '1) begin
                     r_hit_count <= r_hit_count + 1'b1;
                  end
               end else begin
                  if (r_miss_count != '1) begin
                     r_miss_count <= r_miss_count + 1'b1;
                  end
               end
               r_state <= S_RESP;
            end
            S_RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_cam_en    <= 1'b0;
               r_cam_we    <= 1'b0;
               r_rsp_valid <= 1'b0;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cam_access_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_cam_access_arbiter                                      |
// | Description : Directed self-checking bench for cam_access_arbiter with a |
// |               behavioural 16x8 CAM (lookup registers match, update       |
// |               inserts the key on a miss at the next free 1-based slot).  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_cam_access_arbiter;

   logic        clk;
   logic        reset;
   logic [3:0]  req_valid;
   logic [31:0] req_key;
   logic [3:0]  req_ready;
   logic        rsp_valid;
   logic [1:0]  rsp_id;
   logic        rsp_hit;
   logic [3:0]  rsp_addr;
   logic        rsp_ready;
   logic        cam_en;
   logic        cam_we;
   logic [7:0]  cam_din;
   logic        cam_match;
   logic [3:0]  cam_match_addr;
   logic        busy;
   logic [15:0] hit_count;
   logic [15:0] miss_count;

   // Second instance with narrow counters, driven by the same stimulus.
   logic [3:0]  s_req_ready;
   logic        s_rsp_valid;
   logic [1:0]  s_rsp_id;
   logic        s_rsp_hit;
   logic [3:0]  s_rsp_addr;
   logic        s_cam_en;
   logic        s_cam_we;
   logic [7:0]  s_cam_din;
   logic        s_busy;
   logic [1:0]  s_hit_count;
   logic [1:0]  s_miss_count;

   int n_checks = 0;
   int n_fail   = 0;

   cam_access_arbiter u_dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_key(req_key),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
      .rsp_hit(rsp_hit), .rsp_addr(rsp_addr), .rsp_ready(rsp_ready),
      .cam_en(cam_en), .cam_we(cam_we), .cam_din(cam_din),
      .cam_match(cam_match), .cam_match_addr(cam_match_addr), .busy(busy),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   cam_access_arbiter #(.CNT_WIDTH(2)) u_dut_sat (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_key(req_key),
      .req_ready(s_req_ready), .rsp_valid(s_rsp_valid), .rsp_id(s_rsp_id),
      .rsp_hit(s_rsp_hit), .rsp_addr(s_rsp_addr), .rsp_ready(rsp_ready),
      .cam_en(s_cam_en), .cam_we(s_cam_we), .cam_din(s_cam_din),
      .cam_match(cam_match), .cam_match_addr(cam_match_addr), .busy(s_busy),
      .hit_count(s_hit_count), .miss_count(s_miss_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural CAM model
   logic [7:0] cam_mem [16];
   logic [4:0] cam_used;

   always @(posedge clk) begin : cam_model
      logic       f;
      logic [3:0] a;
      f = 1'b0;
      a = 4'd0;
      if (reset) begin
         cam_used       <= '0;
         cam_match      <= 1'b0;
         cam_match_addr <= '0;
      end else if (cam_en && !cam_we) begin
         for (int i = 0; i < 16; i++) begin
            if (i < int'(cam_used) && cam_mem[i] == cam_din && !f) begin
               f = 1'b1;
               a = 4'(i + 1);
            end
         end
         cam_match      <= f;
         cam_match_addr <= a;
      end else if (cam_en && cam_we) begin
         if (!cam_match && cam_used < 5'd16) begin
            cam_mem[cam_used[3:0]] <= cam_din;
            cam_used               <= cam_used + 5'd1;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One full transaction starting at an IDLE negedge, ending at the IDLE
   // negedge after the response has been accepted.
   task automatic run_txn(input int r, input logic [7:0] key,
                          input logic exp_hit, input logic [3:0] exp_addr);
      logic [3:0] onehot;
      onehot = 4'(1 << r);
      req_valid          = onehot;
      req_key[r*8 +: 8]  = key;
      #1;
      chk("txn_req_ready", req_ready, onehot);
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      chk("txn_rsp_valid", rsp_valid, 1);
      chk("txn_rsp_id", rsp_id, r);
      chk("txn_rsp_hit", rsp_hit, exp_hit);
      chk("txn_rsp_addr", rsp_addr, exp_addr);
      @(negedge clk);
      chk("txn_rsp_drop", rsp_valid, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [3:0] exp_g;
      reset     = 1'b1;
      req_valid = '0;
      req_key   = '0;
      rsp_ready = 1'b1;
      repeat (3) @(negedge clk);

      // Reset state; requests during reset must not be accepted
      req_valid = 4'hF;
      #1;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_cam_en", cam_en, 0);
      chk("rst_cam_we", cam_we, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_hit_count", hit_count, 0);
      chk("rst_miss_count", miss_count, 0);
      req_valid = '0;
      reset     = 1'b0;
      @(negedge clk);

      // Single request from req 0, key 3C: miss
      req_valid     = 4'b0001;
      req_key[7:0]  = 8'h3C;
      #1;
      chk("t1_grant", req_ready, 4'b0001);
      @(negedge clk);
      req_valid = '0;
      chk("t1_lookup_en", cam_en, 1);
      chk("t1_lookup_we", cam_we, 0);
      chk("t1_lookup_din", cam_din, 8'h3C);
      chk("t1_busy", busy, 1);
      @(negedge clk);
      chk("t1_update_en", cam_en, 1);
      chk("t1_update_we", cam_we, 1);
      chk("t1_update_din", cam_din, 8'h3C);
      @(negedge clk);
      chk("t1_capture_en", cam_en, 0);
      chk("t1_capture_rsp_valid", rsp_valid, 0);
      @(negedge clk);
      chk("t1_rsp_valid", rsp_valid, 1);
      chk("t1_rsp_id", rsp_id, 0);
      chk("t1_rsp_hit", rsp_hit, 0);
      chk("t1_rsp_addr", rsp_addr, 0);
      chk("t1_miss_count", miss_count, 1);
      chk("t1_hit_count", hit_count, 0);
      @(negedge clk);
      chk("t1_idle_rsp_valid", rsp_valid, 0);
      chk("t1_idle_busy", busy, 0);

      // Same key from req 2: hit at location 1
      run_txn(2, 8'h3C, 1'b1, 4'd1);
      chk("t2_hit_count", hit_count, 1);
      chk("t2_miss_count", miss_count, 1);

      // Reset pulse so the round-robin pointer starts at 0 again
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;

      // All four requesting: grants 0,1,2,3,0 each 5 cycles apart
      req_valid = 4'hF;
      req_key   = {8'h13, 8'h12, 8'h11, 8'h10};
      for (int t = 0; t < 5; t++) begin
         exp_g = 4'(1 << (t % 4));
         #1;
         chk("t3_grant", req_ready, exp_g);
         for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk("t3_ready_low", req_ready, 0);
            if (c == 4) begin
               chk("t3_rsp_valid", rsp_valid, 1);
               chk("t3_rsp_id", rsp_id, t % 4);
               chk("t3_rsp_hit", rsp_hit, (t == 4) ? 1 : 0);
               chk("t3_rsp_addr", rsp_addr, (t == 4) ? 1 : 0);
               if (t == 4) req_valid = '0;
            end
         end
         @(negedge clk);
      end
      chk("t3_miss_count", miss_count, 4);
      chk("t3_hit_count", hit_count, 1);
      chk("t3_idle_busy", busy, 0);

      // Back-pressure: req 3 (key 13) served while req 1 waits
      req_valid = 4'b1000;
      #1;
      chk("t4_grant3", req_ready, 4'b1000);
      @(negedge clk);
      req_valid = 4'b0010;
      rsp_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk("t4_hold_valid", rsp_valid, 1);
         chk("t4_hold_id", rsp_id, 3);
         chk("t4_hold_hit", rsp_hit, 1);
         chk("t4_hold_addr", rsp_addr, 4);
         chk("t4_hold_ready", req_ready, 0);
         chk("t4_hold_cam_en", cam_en, 0);
      end
      chk("t4_hit_count", hit_count, 2);
      rsp_ready = 1'b1;
      @(negedge clk);
      #1;
      chk("t4_grant1", req_ready, 4'b0010);
      chk("t4_rsp_drop", rsp_valid, 0);

      // Reset in the UPDATE cycle aborts the req 1 transaction
      @(negedge clk);
      req_valid = '0;
      chk("t5_lookup_din", cam_din, 8'h11);
      @(negedge clk);
      chk("t5_update_we", cam_we, 1);
      reset = 1'b1;
      @(negedge clk);
      chk("t5_busy", busy, 0);
      chk("t5_cam_en", cam_en, 0);
      chk("t5_rsp_valid", rsp_valid, 0);
      chk("t5_hit_count", hit_count, 0);
      chk("t5_miss_count", miss_count, 0);
      reset = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk("t5_no_rsp", rsp_valid, 0);
      end

      // Counter saturation on the 2-bit instance
      run_txn(0, 8'h55, 1'b0, 4'd0);
      chk("t6_sat_miss", s_miss_count, 1);
      for (int k = 1; k <= 4; k++) begin
         run_txn(0, 8'h55, 1'b1, 4'd1);
         chk("t6_sat_hit", s_hit_count, (k > 3) ? 3 : k);
      end
      chk("t6_main_hit", hit_count, 4);
      chk("t6_main_miss", miss_count, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
